rc4_key_search_scheduler: RTL

Sequencer and S-memory arbiter for the RC4 key-search datapath. For each candidate key it runs the three engines in order: S-array init, KSA shuffle, then message decryption. While an engine runs, the scheduler grants it the single-port S memory. It then advances the secret key until the decryptor reports a readable message or the key space is exhausted. It sits between the top level (switches/LEDs/HEX) and the `s_memory` RAM.

---
 rtl/rc4_key_search_scheduler_if.sv | 51 +++++
 rtl/rc4_key_search_scheduler.sv | 134 +++++++++++++
 2 files changed

// File: rtl/rc4_key_search_scheduler_if.sv
// Scheduler-facing bundle: search control/status, engine handshakes,
// per-engine S-memory requests and the granted S-memory port.
interface rc4_key_search_scheduler_if #(
  parameter int unsigned KEY_WIDTH = 24
);
  logic                 start;
  logic [KEY_WIDTH-1:0] secret_key;
  logic                 busy;
  logic                 found;
  logic                 failed;

  logic init_start, ksa_start, dec_start;
  logic init_done, ksa_done, dec_done;
  logic init_done_ack, ksa_done_ack, dec_done_ack;
  logic dec_key_found;

  logic [7:0] init_s_addr, ksa_s_addr, dec_s_addr;
  logic [7:0] init_s_wdata, ksa_s_wdata, dec_s_wdata;
  logic       init_s_wren, ksa_s_wren, dec_s_wren;

  logic [7:0] s_addr;
  logic [7:0] s_wdata;
  logic       s_wren;
  logic [1:0] s_owner;

  modport master (
    input  start,
    output secret_key, busy, found, failed,
    output init_start, ksa_start, dec_start,
    input  init_done, ksa_done, dec_done,
    output init_done_ack, ksa_done_ack, dec_done_ack,
    input  dec_key_found,
    input  init_s_addr, ksa_s_addr, dec_s_addr,
    input  init_s_wdata, ksa_s_wdata, dec_s_wdata,
    input  init_s_wren, ksa_s_wren, dec_s_wren,
    output s_addr, s_wdata, s_wren, s_owner
  );

  modport slave (
    output start,
    input  secret_key, busy, found, failed,
    input  init_start, ksa_start, dec_start,
    output init_done, ksa_done, dec_done,
    input  init_done_ack, ksa_done_ack, dec_done_ack,
    output dec_key_found,
    output init_s_addr, ksa_s_addr, dec_s_addr,
    output init_s_wdata, ksa_s_wdata, dec_s_wdata,
    output init_s_wren, ksa_s_wren, dec_s_wren,
    input  s_addr, s_wdata, s_wren, s_owner
  );
endinterface

// File: rtl/rc4_key_search_scheduler.sv
// RC4 key-search sequencer: runs init -> KSA -> decrypt per candidate key
// and grants the single-port S memory to whichever engine is active.
module rc4_key_search_scheduler #(
  parameter int unsigned          KEY_WIDTH = 24,
  parameter logic [KEY_WIDTH-1:0] KEY_START = KEY_WIDTH'(24'h000000),
  parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(24'h3FFFFF),
  parameter logic [KEY_WIDTH-1:0] KEY_STEP  = KEY_WIDTH'(1)
) (
  input logic                        clk,
  input logic                        reset,
  rc4_key_search_scheduler_if.master bus
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_INIT = 2'd1;
  localparam logic [1:0] OWN_KSA  = 2'd2;
  localparam logic [1:0] OWN_DEC  = 2'd3;

  // Last-key test without computing secret_key + KEY_STEP, which could wrap.
  localparam logic                 STEP_EXCEEDS_MAX = (KEY_STEP > KEY_MAX);
  localparam logic [KEY_WIDTH-1:0] KEY_LAST         = KEY_MAX - KEY_STEP;

  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_WAIT, INIT_ACK,
    KSA_GO, KSA_WAIT, KSA_ACK,
    DEC_GO, DEC_WAIT, DEC_ACK,
    NEXT_KEY, FOUND, FAIL
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   key_found_q;
  logic   key_last;
  logic   start_ok;

  assign key_last = STEP_EXCEEDS_MAX || (bus.secret_key > KEY_LAST);
  assign start_ok = (state == IDLE || state == FOUND || state == FAIL) && bus.start;

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, FOUND, FAIL: if (bus.start) state_nxt = INIT_GO;
      INIT_GO:   state_nxt = INIT_WAIT;
      INIT_WAIT: if (bus.init_done) state_nxt = INIT_ACK;
      INIT_ACK:  state_nxt = KSA_GO;
      KSA_GO:    state_nxt = KSA_WAIT;
      KSA_WAIT:  if (bus.ksa_done) state_nxt = KSA_ACK;
      KSA_ACK:   state_nxt = DEC_GO;
      DEC_GO:    state_nxt = DEC_WAIT;
      DEC_WAIT:  if (bus.dec_done) state_nxt = DEC_ACK;
      DEC_ACK: begin
        if (key_found_q)   state_nxt = FOUND;
        else if (key_last) state_nxt = FAIL;
        else               state_nxt = NEXT_KEY;
      end
      NEXT_KEY:  state_nxt = INIT_GO;
      default:   state_nxt = IDLE;
    endcase
  end

  // State, key and registered Moore outputs (decoded from the upcoming state)
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      bus.secret_key    <= KEY_START;
      key_found_q       <= 1'b0;
      bus.busy          <= 1'b0;
      bus.found         <= 1'b0;
      bus.failed        <= 1'b0;
      bus.init_start    <= 1'b0;
      bus.ksa_start     <= 1'b0;
      bus.dec_start     <= 1'b0;
      bus.init_done_ack <= 1'b0;
      bus.ksa_done_ack  <= 1'b0;
      bus.dec_done_ack  <= 1'b0;
      bus.s_owner       <= OWN_NONE;
    end else begin
      state <= state_nxt;

      if (start_ok)              bus.secret_key <= KEY_START;
      else if (state == NEXT_KEY) bus.secret_key <= bus.secret_key + KEY_STEP;

      if (state == DEC_WAIT && bus.dec_done) key_found_q <= bus.dec_key_found;

      bus.busy          <= !(state_nxt == IDLE || state_nxt == FOUND || state_nxt == FAIL);
      bus.found         <= (state_nxt == FOUND);
      bus.failed        <= (state_nxt == FAIL);
      bus.init_start    <= (state_nxt == INIT_GO);
      bus.ksa_start     <= (state_nxt == KSA_GO);
      bus.dec_start     <= (state_nxt == DEC_GO);
      bus.init_done_ack <= (state_nxt == INIT_ACK);
      bus.ksa_done_ack  <= (state_nxt == KSA_ACK);
      bus.dec_done_ack  <= (state_nxt == DEC_ACK);

      unique case (state_nxt)
        INIT_GO, INIT_WAIT, INIT_ACK: bus.s_owner <= OWN_INIT;
        KSA_GO, KSA_WAIT, KSA_ACK:    bus.s_owner <= OWN_KSA;
        DEC_GO, DEC_WAIT, DEC_ACK:    bus.s_owner <= OWN_DEC;
        default:                      bus.s_owner <= OWN_NONE;
      endcase
    end
  end

  // S-memory port mux; only the owner's write enable can reach the RAM
  always_comb begin
    bus.s_addr  = 8'h00;
    bus.s_wdata = 8'h00;
    bus.s_wren  = 1'b0;
    unique case (bus.s_owner)
      OWN_INIT: begin
        bus.s_addr  = bus.init_s_addr;
        bus.s_wdata = bus.init_s_wdata;
        bus.s_wren  = bus.init_s_wren;
      end
      OWN_KSA: begin
        bus.s_addr  = bus.ksa_s_addr;
        bus.s_wdata = bus.ksa_s_wdata;
        bus.s_wren  = bus.ksa_s_wren;
      end
      OWN_DEC: begin
        bus.s_addr  = bus.dec_s_addr;
        bus.s_wdata = bus.dec_s_wdata;
        bus.s_wren  = bus.dec_s_wren;
      end
      default: begin
        bus.s_addr  = 8'h00;
        bus.s_wdata = 8'h00;
        bus.s_wren  = 1'b0;
      end
    endcase
  end

endmodule
